// File: rtl/uart_rx_framer_if.sv
// AXI-stream style channel (tdata/tvalid/tready) used on both sides of uart_rx_framer.
// DATA_WIDTH_BYTES sets the tdata width in bytes.
interface uart_rx_framer_if #(
  parameter int DATA_WIDTH_BYTES = 1
);
  logic [8*DATA_WIDTH_BYTES-1:0] tdata;
  logic                          tvalid;
  logic                          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_framer.sv
// Packs a UART byte stream little-endian into WORD_BYTES-wide words behind a registered output.
// Optional inter-byte timeout discard is compiled in with `define UART_RX_FRAMER_TIMEOUT_EN.
module uart_rx_framer #(
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                arstn,
  uart_rx_framer_if.slave     s_axis,
  uart_rx_framer_if.master    m_axis,
  output logic                partial,
  output logic                frame_error,
  output logic [15:0]         word_count
);

  localparam int IDXW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORD_BYTES - 1);

  if (WORD_BYTES < 1 || WORD_BYTES > 16 || TIMEOUT_CYCLES < 2) begin : g_paramCheck
    $error("uart_rx_framer: WORD_BYTES must be 1..16 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic {EMPTY, FILL} state_t;

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [8*WORD_BYTES-1:0]     acc_q, acc_d;
  logic [8*WORD_BYTES-1:0]     outData_q, outData_d;
  logic                        outValid_q, outValid_d;
  logic [15:0]                 wordCount_q, wordCount_d;
  logic [8*WORD_BYTES-1:0]     merged;
  logic                        sReady;
  logic                        byteFire;
  logic                        outFire;
  logic                        stall;
  logic                        expire;

  // A new byte may only be refused when it would complete a word and the output slot is still occupied.
  assign sReady   = (idx_q != IDX_LAST) || !outValid_q || m_axis.tready;
  assign byteFire = s_axis.tvalid && sReady;
  assign outFire  = outValid_q && m_axis.tready;
  assign stall    = s_axis.tvalid && !sReady;

  assign s_axis.tready = sReady;
  assign m_axis.tvalid = outValid_q;
  assign m_axis.tdata  = outData_q;
  assign partial       = (state_q == FILL);
  assign word_count    = wordCount_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= EMPTY;
      idx_q       <= '0;
      acc_q       <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      wordCount_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      wordCount_q <= wordCount_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    outData_d   = outData_q;
    outValid_d  = outValid_q;
    wordCount_d = wordCount_q;
    merged      = acc_q;
    merged[8*IDX_LAST +: 8] = s_axis.tdata[7:0];

    if (outFire) begin
      outValid_d  = 1'b0;
      wordCount_d = wordCount_q + 16'd1;
    end

    // A completing byte loads the output register, overriding a drain in the same cycle.
    if (byteFire) begin
      acc_d[8*idx_q +: 8] = s_axis.tdata[7:0];
      if (idx_q == IDX_LAST) begin
        outData_d  = merged;
        outValid_d = 1'b1;
        idx_d      = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (expire) begin
      idx_d = '0;
    end

    state_d = (idx_d == '0) ? EMPTY : FILL;
  end

`ifdef UART_RX_FRAMER_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(TIMEOUT_CYCLES);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            frameError_q, frameError_d;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_q        <= '0;
      frameError_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frameError_q <= frameError_d;
    end
  end

  // Idle-cycle counter; a waiting but refused byte freezes it so back-pressure never discards data.
  always_comb begin
    cnt_d        = cnt_q;
    frameError_d = 1'b0;
    expire       = (state_q == FILL) && (cnt_q == CNT_LIMIT) && !byteFire && !stall;
    if (state_q == EMPTY || byteFire || expire) begin
      cnt_d = '0;
    end else if (!stall && cnt_q != CNT_LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    frameError_d = expire;
  end

  assign frame_error = frameError_q;
`else
  assign expire      = 1'b0;
  assign frame_error = 1'b0;
`endif

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Receive-side framing stage between the UART byte stream (`uart` `m_axis`, 1-byte AXIS) and the processor-width AXIS consumed by the network core. It packs consecutive received bytes, little-endian, into `WORD_BYTES`-wide words and presents each completed word through a registered output. An optional inter-byte timeout discards partially received words, so a dropped byte on the serial line cannot misalign every later word. It replaces the generic rx-side `axis_adapter` wherever framing recovery is required.

## Interface
- `WORD_BYTES`, 4: output word width in bytes, 1..16.
- `TIMEOUT_CYCLES`, 100000: idle clock cycles allowed after an accepted byte while a word is partial, ≥2; unused unless timeout is compiled in.
- `clk`  in  1  system clock.
- `arstn`  in  1  asynchronous active-low reset.
- `s_axis`  axis slave  `DATA_WIDTH_BYTES=1`  byte stream from UART; uses `tdata[7:0]`, `tvalid`, `tready`.
- `m_axis`  axis master  `DATA_WIDTH_BYTES=WORD_BYTES`  packed words; uses `tdata`, `tvalid`, `tready`.
- `partial`  out  1  high while 1..`WORD_BYTES`-1 bytes of the current word are held.
- `frame_error`  out  1  one-cycle pulse when a partial word is discarded by timeout.
- `word_count`  out  16  count of words handed off on `m_axis`, wraps 0xFFFF→0.

## Operation
- Byte index `idx` (0..`WORD_BYTES`-1), accumulator `acc`, output register `out_data`/`out_valid`.
- Byte handshake: `s_axis.tvalid && s_axis.tready`. The byte accepted at `idx`=k goes to `acc[8k+7:8k]`; first byte received → `tdata[7:0]`.
- `s_axis.tready` = `(idx != WORD_BYTES-1) || !out_valid || m_axis.tready` (combinational).
- On the byte that completes a word (`idx`=`WORD_BYTES`-1): `out_data` ← `{byte, acc[...]}`, `out_valid` ← 1, `idx` ← 0. The accumulator bytes are don't-care after this.
- `m_axis.tvalid` = `out_valid`, `m_axis.tdata` = `out_data`. On output handshake `out_valid` clears unless a new word loads in the same cycle. On handshake `word_count` increments.
- Output held stable while `tvalid && !tready` (AXIS rule); `out_data` changes only on load.
- States: EMPTY (`idx`=0), FILL (`idx`>0). `partial` = (state == FILL).
- `WORD_BYTES`=1: pure registered pass-through, always EMPTY, `partial` constant 0.
- Reset mid-word: all held bytes and the output word are lost, no `frame_error`.

## Timing
- Reset values: `m_axis.tvalid`=0, `m_axis.tdata`=0, `partial`=0, `frame_error`=0, `word_count`=0, `idx`=0. `s_axis.tready`=1 out of reset.
- Latency: completing byte accepted at cycle N → `m_axis.tvalid` high at N+1.
- Throughput: one byte per cycle sustained when downstream `tready` is held high. No bubble when a word completes in the same cycle the previous word drains.
- Timeout counter: cleared on every accepted byte and while EMPTY. It increments each FILL cycle with no accepted byte. It freezes while `s_axis.tvalid && !s_axis.tready`.
- Expiry: the counter reaches `TIMEOUT_CYCLES`, i.e. `TIMEOUT_CYCLES` idle cycles after the last accepted byte. On the next edge `idx` ← 0 and `frame_error` pulses for exactly 1 cycle. The pending `out_valid` word is unaffected.
- A byte accepted in the expiry cycle wins: no discard, counter cleared, byte appended.

## Configuration
- `UART_RX_FRAMER_TIMEOUT_EN` defined: timeout counter and discard logic present, behaviour as above.
- Not defined: counter removed, partial words are held indefinitely, `frame_error` tied to 0, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- `WORD_BYTES`=4, bytes 0x11,0x22,0x33,0x44 back-to-back, `m_axis.tready`=1 → one word 0x44332211, `tvalid` one cycle after 0x44 accepted, `word_count`=1.
- 8 bytes 0x01..0x08 streamed, `m_axis.tready`=0 for 20 cycles → 0x04030201 held stable. `s_axis.tready` drops on byte 0x08 until release, then 0x08070605 follows with no data loss.
- Timeout enabled, `TIMEOUT_CYCLES`=16: send 0xAA,0xBB, then idle → `frame_error` pulses once 16 idle cycles after 0xBB, `partial`→0. Next 0x01..0x04 → 0x04030201.
- Byte presented exactly in the expiry cycle → no `frame_error`, byte becomes byte index 2 of the current word.
- Assert `arstn` low after 3 bytes with one word pending → all outputs return to reset values. Bytes 0x10..0x13 after release → 0x13121110.
- `WORD_BYTES`=1, 65537 bytes at full rate → every byte out 1 cycle later, `word_count` wraps to 1.
